// File: rtl/fifo_fill_engine.sv
// Read-side DMA engine: asks the fill FSM for a refill when the pixel FIFO drops
// below half, then fetches WORDS_PER_FILL words as fixed bursts into the FIFO.
//
//   state   | meaning
//   IDLE    | watching fifo_count; may request a fill or take an unsolicited go
//   WAIT_GO | request sent, waiting for go_fill_fifo
//   CMD     | burst read command presented, waiting for mst_cmd_ack
//   DATA    | collecting BURST_WORDS beats and pushing them into the FIFO
module fifo_fill_engine #(
    parameter int WORDS_PER_FILL = 256,
    parameter int BURST_WORDS    = 16,
    parameter int FIFO_DEPTH     = 512,
    parameter int FIFO_CNT_W     = 10,
    parameter int HALF_LEVEL     = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  go_fill_fifo,
    input  logic [31:0]           ddr_addr_to_read,
    output logic                  fill_half_fifo,
    output logic                  mst_rd_req,
    output logic [31:0]           mst_addr,
    input  logic                  mst_cmd_ack,
    input  logic [31:0]           mst_rd_data,
    input  logic                  mst_rd_valid,
    output logic                  fifo_wr_en,
    output logic [31:0]           fifo_wr_data,
    input  logic [FIFO_CNT_W-1:0] fifo_count,
    output logic                  busy,
    output logic                  err_overrun,
    output logic                  err_fifo_ovf,
    output logic                  err_stray
);

    localparam int BURSTS  = WORDS_PER_FILL / BURST_WORDS;
    localparam int BEAT_W  = $clog2(BURST_WORDS) + 1;
    localparam int BURST_W = $clog2(BURSTS) + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_GO, S_CMD, S_DATA} state_t;

    state_t               state_q, state_d;
    logic [31:0]          addr_q;
    logic [BEAT_W-1:0]    beat_q;
    logic [BURST_W-1:0]   burst_q;
    logic                 start, req_cond, beat_ok, last_beat, last_burst;

    assign start      = go_fill_fifo && (state_q == S_IDLE || state_q == S_WAIT_GO);
    // busy still high in IDLE means the final push is on the bus this cycle
    assign req_cond   = (state_q == S_IDLE) && !go_fill_fifo && !busy && enable &&
                        (fifo_count < FIFO_CNT_W'(HALF_LEVEL));
    assign beat_ok    = (state_q == S_DATA) && mst_rd_valid;
    assign last_beat  = beat_ok && (beat_q == BEAT_W'(BURST_WORDS - 1));
    assign last_burst = (burst_q == BURST_W'(1));

    assign mst_rd_req = (state_q == S_CMD);
    assign mst_addr   = addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start)         state_d = S_CMD;
                else if (req_cond) state_d = S_WAIT_GO;
            end
            S_WAIT_GO: if (go_fill_fifo) state_d = S_CMD;
            S_CMD:     if (mst_cmd_ack)  state_d = S_DATA;
            S_DATA:    if (last_beat)    state_d = last_burst ? S_IDLE : S_CMD;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_half_fifo <= 1'b0;
            addr_q         <= '0;
            beat_q         <= '0;
            burst_q        <= '0;
            fifo_wr_en     <= 1'b0;
            fifo_wr_data   <= '0;
            busy           <= 1'b0;
            err_overrun    <= 1'b0;
            err_fifo_ovf   <= 1'b0;
            err_stray      <= 1'b0;
        end else begin
            fill_half_fifo <= req_cond;
            fifo_wr_en     <= beat_ok;
            if (beat_ok) fifo_wr_data <= mst_rd_data;

            if (start) begin
                addr_q  <= ddr_addr_to_read & 32'hFFFF_FFFC;
                burst_q <= BURST_W'(BURSTS);
                busy    <= 1'b1;
            end else if (state_q == S_IDLE) begin
                busy    <= 1'b0;
            end

            if (state_q == S_CMD && mst_cmd_ack) beat_q <= '0;
            if (beat_ok) beat_q <= beat_q + BEAT_W'(1);
            // address wraps modulo 2^32 by design
            if (last_beat) begin
                addr_q  <= addr_q + 32'(BURST_WORDS * 4);
                burst_q <= burst_q - BURST_W'(1);
            end

            err_overrun  <= err_overrun  | (go_fill_fifo && busy);
            err_fifo_ovf <= err_fifo_ovf | (fifo_wr_en && (fifo_count == FIFO_CNT_W'(FIFO_DEPTH)));
            err_stray    <= err_stray    | (mst_rd_valid && state_q != S_DATA);
        end
    end

endmodule

// File: tb/tb_fifo_fill_engine.sv
// Directed bench for fifo_fill_engine: IDLE-decision vector table, then
// multi-cycle fill, gap, error, wrap and mid-burst reset sequences.
module tb_fifo_fill_engine;

    logic        clk = 1'b0;
    logic        reset, enable, go_fill_fifo, mst_cmd_ack, mst_rd_valid;
    logic [31:0] ddr_addr_to_read, mst_rd_data;
    logic [9:0]  fifo_count;
    logic        fill_half_fifo, mst_rd_req, fifo_wr_en, busy;
    logic        err_overrun, err_fifo_ovf, err_stray;
    logic [31:0] mst_addr, fifo_wr_data;

    int errors = 0;
    int checks = 0;
    logic [31:0] push_q[$];

    fifo_fill_engine dut (
        .clk(clk), .reset(reset), .enable(enable), .go_fill_fifo(go_fill_fifo),
        .ddr_addr_to_read(ddr_addr_to_read), .fill_half_fifo(fill_half_fifo),
        .mst_rd_req(mst_rd_req), .mst_addr(mst_addr), .mst_cmd_ack(mst_cmd_ack),
        .mst_rd_data(mst_rd_data), .mst_rd_valid(mst_rd_valid),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_count(fifo_count),
        .busy(busy), .err_overrun(err_overrun), .err_fifo_ovf(err_fifo_ovf),
        .err_stray(err_stray)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (fifo_wr_en) push_q.push_back(fifo_wr_data);

    typedef struct {
        logic        en;
        logic [9:0]  cnt;
        logic        go;
        logic [31:0] addr;
        logic        vld;
        logic        exp_fill;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_stray;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return {fill_half_fifo, mst_rd_req, mst_addr, fifo_wr_en, fifo_wr_data,
                busy, err_overrun, err_fifo_ovf, err_stray};
    endfunction

    task automatic do_reset(input logic en, input logic [9:0] cnt);
        reset = 1'b1; enable = en; fifo_count = cnt;
        go_fill_fifo = 1'b0; mst_cmd_ack = 1'b0; mst_rd_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (mst_rd_req) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic start_go(input logic [31:0] addr);
        go_fill_fifo = 1'b1; ddr_addr_to_read = addr;
        tick();
        go_fill_fifo = 1'b0;
    endtask

    // Bus slave: nb bursts from base, data = global beat index.
    task automatic run_fill(input logic [31:0] base, input int nb, input int ack_dly,
                            input bit gaps, input int inj_burst);
        int start_idx, bad;
        bit ok;
        logic [31:0] a;
        start_idx = push_q.size();
        for (int k = 0; k < nb; k++) begin
            wait_req(ok);
            if (!ok) begin check("req_timeout", mst_rd_req, 1); return; end
            a = base + 32'(k * 64);
            check("cmd_addr", mst_addr, a);
            for (int d = 0; d < ack_dly; d++) begin
                tick();
                check("addr_hold", {mst_rd_req, mst_addr}, {1'b1, a});
            end
            mst_cmd_ack = 1'b1;
            tick();
            mst_cmd_ack = 1'b0;
            check("req_release", mst_rd_req, 0);
            for (int b = 0; b < 16; b++) begin
                if (gaps && $urandom_range(0, 2) == 0) begin
                    mst_rd_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) tick();
                end
                mst_rd_valid     = 1'b1;
                mst_rd_data      = 32'(k * 16 + b);
                go_fill_fifo     = (k == inj_burst && b == 3);
                ddr_addr_to_read = 32'hDEAD_0000;
                tick();
            end
            mst_rd_valid = 1'b0;
            go_fill_fifo = 1'b0;
        end
        if (nb == 16) begin
            check("last_push_en", fifo_wr_en, 1);
            check("busy_at_last_push", busy, 1);
            tick();
            check("busy_fall", busy, 0);
            check("push_count", push_q.size() - start_idx, 256);
            bad = 0;
            for (int i = 0; i < 256; i++)
                if (start_idx + i < push_q.size() && push_q[start_idx + i] !== 32'(i)) bad++;
            check("push_order", bad, 0);
        end
    endtask

    initial begin
        bit ok;
        vecs[0] = '{1'b1, 10'd100, 1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0,          1'b0};
        vecs[1] = '{1'b1, 10'd300, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 32'h0,          1'b0};
        vecs[2] = '{1'b1, 10'd255, 1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0,          1'b0};
        vecs[3] = '{1'b1, 10'd256, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 32'h0,          1'b0};
        vecs[4] = '{1'b0, 10'd0,   1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 32'h0,          1'b0};
        vecs[5] = '{1'b1, 10'd0,   1'b0, 32'h0,          1'b1, 1'b1, 1'b0, 32'h0,          1'b1};
        vecs[6] = '{1'b1, 10'd10,  1'b1, 32'hFFFF_FF03,  1'b0, 1'b0, 1'b1, 32'hFFFF_FF00,  1'b0};
        vecs[7] = '{1'b0, 10'd300, 1'b1, 32'h1234_5677,  1'b0, 1'b0, 1'b1, 32'h1234_5674,  1'b0};
        vecs[8] = '{1'b1, 10'd511, 1'b0, 32'h0,          1'b1, 1'b0, 1'b0, 32'h0,          1'b1};

        reset = 1'b1; enable = 1'b0; go_fill_fifo = 1'b0; mst_cmd_ack = 1'b0;
        mst_rd_valid = 1'b0; mst_rd_data = '0; ddr_addr_to_read = '0; fifo_count = '0;
        tick(); tick();
        check("reset_outputs", outs(), 0);

        // IDLE decision table: one cycle after reset release
        for (int i = 0; i < 9; i++) begin
            do_reset(vecs[i].en, vecs[i].cnt);
            go_fill_fifo = vecs[i].go; ddr_addr_to_read = vecs[i].addr;
            mst_rd_valid = vecs[i].vld;
            tick();
            go_fill_fifo = 1'b0; mst_rd_valid = 1'b0;
            check($sformatf("vec%0d_fill", i), fill_half_fifo, vecs[i].exp_fill);
            check($sformatf("vec%0d_req", i), {mst_rd_req, busy}, {2{vecs[i].exp_req}});
            check($sformatf("vec%0d_addr", i), mst_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_stray", i), err_stray, vecs[i].exp_stray);
            tick();
            check($sformatf("vec%0d_fill_once", i), fill_half_fifo, 0);
        end

        // request, start, full fill with immediate acks
        do_reset(1'b1, 10'd100);
        tick();
        check("req_pulse", fill_half_fifo, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_pulse_waiting", fill_half_fifo, 0);
        end
        start_go(32'hA800_0000);
        check("cmd_issue", {mst_rd_req, busy, mst_addr}, {2'b11, 32'hA800_0000});
        run_fill(32'hA800_0000, 16, 0, 1'b0, -1);
        tick();
        check("re_request", fill_half_fifo, 1);
        check("no_errors", {err_overrun, err_fifo_ovf, err_stray}, 0);

        // delayed acks and data gaps, then threshold behaviour
        fifo_count = 10'd300;
        start_go(32'h1000_0000);
        run_fill(32'h1000_0000, 16, 5, 1'b1, -1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_pulse_300", fill_half_fifo, 0);
        end
        fifo_count = 10'd255;
        tick();
        check("pulse_255", fill_half_fifo, 1);
        tick();
        check("pulse_255_once", fill_half_fifo, 0);

        // go during DATA: flagged, address sequence untouched
        fifo_count = 10'd300;
        start_go(32'h2000_0000);
        run_fill(32'h2000_0000, 16, 0, 1'b0, 2);
        check("err_overrun", {err_overrun, err_fifo_ovf, err_stray}, 3'b100);

        // pushes into a full FIFO, then stray beat in IDLE
        do_reset(1'b0, 10'd512);
        start_go(32'h0000_0000);
        check("ovf_before", err_fifo_ovf, 0);
        run_fill(32'h0000_0000, 16, 0, 1'b0, -1);
        check("err_fifo_ovf", {err_overrun, err_fifo_ovf, err_stray}, 3'b010);
        mst_rd_valid = 1'b1;
        tick();
        mst_rd_valid = 1'b0;
        check("err_stray", {err_fifo_ovf, err_stray}, 2'b11);

        // misaligned start near top of address space
        do_reset(1'b0, 10'd300);
        start_go(32'hFFFF_FF03);
        run_fill(32'hFFFF_FF00, 16, 0, 1'b0, -1);

        // reset in the middle of burst 3
        do_reset(1'b0, 10'd300);
        start_go(32'h3000_0000);
        run_fill(32'h3000_0000, 2, 0, 1'b0, -1);
        wait_req(ok);
        check("burst3_addr", {mst_rd_req, mst_addr}, {1'b1, 32'h3000_0080});
        mst_cmd_ack = 1'b1;
        tick();
        mst_cmd_ack = 1'b0;
        for (int b = 0; b < 5; b++) begin
            mst_rd_valid = 1'b1; mst_rd_data = 32'(b);
            tick();
        end
        #2 reset = 1'b1;
        #1 check("async_reset", outs(), 0);
        enable = 1'b1; fifo_count = 10'd50;
        tick();
        reset = 1'b0;
        tick();
        mst_rd_valid = 1'b0;
        check("post_reset_pulse", fill_half_fifo, 1);
        check("post_reset_stray", {err_overrun, err_stray}, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
